// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI-style burst memory slave with independent read and write engines
module axi_slave_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W = 4,
  parameter int LEN_W = 4,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [ID_W-1:0]   RID,
  output logic [1:0]        RRESP,
  output logic              RLAST
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [ID_W-1:0]   w_id, r_id;
  logic [LEN_W-1:0]  w_len, r_len;
  logic [LEN_W:0]    w_cnt, r_cnt;
  logic w_err, aw_hs, w_hs, b_hs, ar_hs, r_hs, w_ok, r_ok, w_final;
  // Outputs are gated by rst so they read zero for the whole reset cycle
  always_comb begin
    AWREADY = !rst && w_state == W_IDLE;
    WREADY  = !rst && w_state == W_DATA;
    BVALID  = !rst && w_state == W_RESP;
    ARREADY = !rst && r_state == R_IDLE;
    RVALID  = !rst && r_state == R_DATA;
    aw_hs   = AWVALID && AWREADY;
    w_hs    = WVALID && WREADY;
    b_hs    = BVALID && BREADY;
    ar_hs   = ARVALID && ARREADY;
    r_hs    = RVALID && RREADY;
    w_ok    = {1'b0, w_addr} < LIM;
    r_ok    = {1'b0, r_addr} < LIM;
    w_final = w_cnt == {1'b0, w_len};
    BID     = BVALID ? w_id : '0;
    BRESP   = (BVALID && w_err) ? 2'b10 : 2'b00;
    RID     = RVALID ? r_id : '0;
    RRESP   = (RVALID && !r_ok) ? 2'b10 : 2'b00;
    RLAST   = RVALID && r_cnt == {1'b0, r_len};
    RDATA   = (RVALID && r_ok) ? mem[r_addr[IW-1:0]] : '0;
    w_next  = aw_hs ? W_DATA : (w_hs && w_final) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_next  = ar_hs ? R_DATA : (r_hs && RLAST) ? R_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_addr  <= '0;
      r_addr  <= '0;
      w_id    <= '0;
      r_id    <= '0;
      w_len   <= '0;
      r_len   <= '0;
      w_cnt   <= '0;
      r_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs) begin
        w_addr <= AWADDR;
        w_id   <= AWID;
        w_len  <= AWLEN;
        w_cnt  <= '0;
        w_err  <= 1'b0;
      end else if (w_hs) begin
        w_addr <= w_addr + 1'b1;
        w_cnt  <= w_cnt + 1'b1;
        w_err  <= w_err | !w_ok | (WLAST != w_final);
      end
      if (ar_hs) begin
        r_addr <= ARADDR;
        r_id   <= ARID;
        r_len  <= ARLEN;
        r_cnt  <= '0;
      end else if (r_hs) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
  // Storage is deliberately outside reset so an aborted burst keeps its beats
  always_ff @(posedge clk) begin
    if (w_hs && w_ok) mem[w_addr[IW-1:0]] <= WDATA;
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized bench with a transaction-level memory model checked every cycle
module tb_axi_slave_mem;
  localparam int DEPTH = 64;
  logic clk = 0, rst = 1;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [7:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0] AWID, ARID, AWLEN, ARLEN, BID, RID;
  logic [1:0] BRESP, RRESP;

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0, cyc = 0;
  logic [7:0] mem_m [DEPTH];
  bit known [DEPTH];
  int w_ph = 0, r_ph = 0, w_a, r_a, w_left, r_left, aw_cyc = -1, ar_cyc = -2;
  logic [3:0] w_idm, r_idm;
  bit w_errm;
  logic [5:0] b_log [$];
  logic [10:0] r_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: per-burst phase, address and remaining beats; memory as a plain array
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RRESP, RDATA}, 0);
      w_ph = 0;
      r_ph = 0;
    end else begin
      chk("awready", AWREADY, w_ph == 0);
      chk("wready", WREADY, w_ph == 1);
      chk("bvalid", BVALID, w_ph == 2);
      if (w_ph == 2) chk("bid_bresp", {BID, BRESP}, {w_idm, w_errm ? 2'b10 : 2'b00});
      chk("arready", ARREADY, r_ph == 0);
      chk("rvalid", RVALID, r_ph == 1);
      if (r_ph == 1) begin
        chk("rid", RID, r_idm);
        chk("rlast", RLAST, r_left == 1);
        chk("rresp", RRESP, r_a < DEPTH ? 0 : 2);
        if (r_a >= DEPTH) chk("rdata_oor", RDATA, 0);
        else if (known[r_a]) chk("rdata", RDATA, mem_m[r_a]);
      end
      if (w_ph == 0 && AWVALID) begin
        w_ph = 1; w_a = AWADDR; w_idm = AWID; w_left = AWLEN + 1; w_errm = 0; aw_cyc = cyc;
      end else if (w_ph == 1 && WVALID) begin
        if (w_a < DEPTH) begin mem_m[w_a] = WDATA; known[w_a] = 1; end
        else w_errm = 1;
        if (WLAST != (w_left == 1)) w_errm = 1;
        w_a = (w_a + 1) % 256;
        w_left--;
        if (w_left == 0) w_ph = 2;
      end else if (w_ph == 2 && BREADY) begin
        b_log.push_back({BID, BRESP});
        w_ph = 0;
      end
      if (r_ph == 0 && ARVALID) begin
        r_ph = 1; r_a = ARADDR; r_idm = ARID; r_left = ARLEN + 1; ar_cyc = cyc;
      end else if (r_ph == 1 && RREADY) begin
        r_log.push_back({RDATA, RRESP, RLAST});
        r_a = (r_a + 1) % 256;
        r_left--;
        if (r_left == 0) r_ph = 0;
      end
    end
  end

  task automatic wait_sig(input int which, input string nm);
    int n = 0;
    logic s;
    do begin
      @(negedge clk);
      s = which == 0 ? AWREADY : which == 1 ? WREADY : which == 2 ? BVALID : ARREADY;
      @(posedge clk); #2;
      n++;
    end while (!s && n < 300);
    if (!s) begin
      compared++; mismatched++;
      $display("FAIL timeout_%s: no handshake in 300 cycles, required one", nm);
    end
  endtask

  task automatic do_write(input int addr, id, len, d0, step, last_at, input bit rnd);
    AWVALID = 1; AWADDR = 8'(addr); AWID = 4'(id); AWLEN = 4'(len);
    wait_sig(0, "aw");
    AWVALID = 0;
    for (int i = 0; i <= len; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      WVALID = 1; WDATA = rnd ? 8'($urandom) : 8'(d0 + i * step); WLAST = (i == last_at);
      wait_sig(1, "w");
      WVALID = 0; WLAST = 0;
    end
    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    BREADY = 1;
    wait_sig(2, "b");
    BREADY = 0;
  endtask

  task automatic do_read(input int addr, id, len, mode);
    int k = 0, n = 0;
    ARVALID = 1; ARADDR = 8'(addr); ARID = 4'(id); ARLEN = 4'(len);
    wait_sig(3, "ar");
    ARVALID = 0;
    while (k <= len && n < 400) begin
      RREADY = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (RVALID && RREADY) k++;
      @(posedge clk); #2;
      n++;
    end
    RREADY = 0;
    if (k <= len) begin
      compared++; mismatched++;
      $display("FAIL timeout_r: got %0d beats, required %0d", k, len + 1);
    end
  endtask

  initial begin
    #500000;
    mismatched++;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    AWVALID = 0; AWADDR = 0; AWID = 0; AWLEN = 0; WVALID = 0; WDATA = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARADDR = 0; ARID = 0; ARLEN = 0; RREADY = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    b_log.delete();
    do_write(1, 1, 2, 'h11, 'h11, 2, 0);
    chk("wr1_bcount", b_log.size(), 1);
    chk("wr1_b", b_log[0], {4'd1, 2'b00});
    chk("model_mem1", mem_m[1], 8'h11);
    chk("model_mem2", mem_m[2], 8'h22);
    chk("model_mem3", mem_m[3], 8'h33);
    for (int m = 0; m < 2; m++) begin
      r_log.delete();
      do_read(1, 1, 2, m);
      chk("rd_count", r_log.size(), 3);
      chk("rd_beat0", r_log[0], {8'h11, 2'b00, 1'b0});
      chk("rd_beat1", r_log[1], {8'h22, 2'b00, 1'b0});
      chk("rd_beat2", r_log[2], {8'h33, 2'b00, 1'b1});
    end
    b_log.delete();
    do_write(62, 2, 3, 'hA0, 1, 3, 0);
    chk("oor_b", b_log[0], {4'd2, 2'b10});
    r_log.delete();
    do_read(63, 3, 1, 0);
    chk("oor_beat0", r_log[0], {8'hA1, 2'b00, 1'b0});
    chk("oor_beat1", r_log[1], {8'h00, 2'b10, 1'b1});
    b_log.delete();
    do_write(20, 4, 2, 'h40, 1, 1, 0);
    chk("early_wlast_b", b_log[0], {4'd4, 2'b10});
    chk("early_wlast_mem22", mem_m[22], 8'h42);
    b_log.delete();
    AWVALID = 1; AWADDR = 10; AWID = 5; AWLEN = 3;
    wait_sig(0, "aw");
    AWVALID = 0; WVALID = 1; WDATA = 8'h5A; WLAST = 0;
    wait_sig(1, "w");
    WVALID = 0; rst = 1;
    @(posedge clk); #2 rst = 0;
    repeat (4) begin @(posedge clk); #2; end
    chk("rst_no_b", b_log.size(), 0);
    r_log.delete();
    do_read(10, 6, 0, 0);
    chk("rst_keeps_beat", r_log[0], {8'h5A, 2'b00, 1'b1});
    fork
      do_write(30, 7, 1, 'h70, 1, 1, 0);
      do_read(1, 8, 2, 2);
    join
    chk("aw_ar_same_edge", aw_cyc, ar_cyc);
    for (int b = 0; b < 4; b++) do_write(b * 16, b, 15, 0, 0, 15, 1);
    fork
      for (int i = 0; i < 40; i++) begin
        int a, l, la;
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 70);
        l = $urandom_range(0, 15);
        la = ($urandom_range(0, 9) == 0) ? $urandom_range(0, l) : l;
        do_write(a, $urandom_range(0, 15), l, 0, 0, la, 1);
      end
      for (int j = 0; j < 40; j++) begin
        int a, l;
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 70);
        l = $urandom_range(0, 15);
        do_read(a, $urandom_range(0, 15), l, 2);
      end
    join
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
